// File: rtl/pwm_pkg.sv
// Shared definitions for pwm_meter: register offsets, CTRL/STATUS bit positions, FSM states.
package pwm_pkg;

  localparam logic [7:0] OFF_CTRL   = 8'd0;
  localparam logic [7:0] OFF_STATUS = 8'd1;
  localparam logic [7:0] OFF_LOW    = 8'd2;
  localparam logic [7:0] OFF_HIGH   = 8'd6;
  localparam logic [7:0] OFF_PCNT   = 8'd10;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_CLR   = 1;
  localparam int STAT_VALID = 0;
  localparam int STAT_OVF   = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2
  } state_e;

endpackage

// File: rtl/pwm_sync_filter.sv
// Two-flop synchronizer for the PWM input; PWM_METER_FILTER_EN adds a registered
// 3-sample majority filter (one extra cycle, single-cycle pulses rejected).
module pwm_sync_filter (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], din};
  end

`ifdef PWM_METER_FILTER_EN
  logic [1:0] hist;
  logic       maj;

  assign maj = (sync_q[1] & hist[0]) | (sync_q[1] & hist[1]) | (hist[0] & hist[1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      hist <= '0;
      dout <= 1'b0;
    end else begin
      hist <= {hist[0], sync_q[1]};
      dout <= maj;
    end
  end
`else
  assign dout = sync_q[1];
`endif

endmodule

// File: rtl/pwm_meter.sv
// PWM period meter: measures low/high phase lengths of sig_in, exposes them on a byte
// register window with a tear-free read shadow. Optional input filter: PWM_METER_FILTER_EN.
module pwm_meter
  import pwm_pkg::*;
#(
  parameter int         CNT_W = 32,
  parameter logic [7:0] BASE  = 8'h50
) (
  input  logic             clk,
  input  logic             res,
  input  logic             init,
  input  logic [7:0]       addr,
  input  logic [7:0]       data_in,
  input  logic             we,
  output logic [7:0]       data_out,
  input  logic             sig_in,
  output logic             meas_valid,
  output logic [CNT_W-1:0] low_len,
  output logic [CNT_W-1:0] high_len
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             rst, s, s_prev, fall;
  logic             en, clr, wr_ctrl, valid, ovf;
  logic [7:0]       pcnt, off, rdata;
  logic [2:0]       bsel;
  logic [CNT_W-1:0] lcnt, hcnt;
  logic [2*CNT_W-9:0] shadow;
  logic             start, done, sat;
  logic             unused_wdata;
  state_e           st, nxt;

  assign rst          = res | init;
  assign off          = addr - BASE;
  assign wr_ctrl      = we && (off == OFF_CTRL);
  assign clr          = wr_ctrl && data_in[CTRL_CLR];
  assign fall         = s_prev & ~s;
  assign unused_wdata = ^data_in[7:2];

  pwm_sync_filter u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (sig_in),
    .dout (s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= S_IDLE;
      s_prev <= 1'b0;
    end else begin
      st     <= nxt;
      s_prev <= s;
    end
  end

  always_comb begin
    nxt   = st;
    start = 1'b0;
    done  = 1'b0;
    sat   = 1'b0;
    unique case (st)
      S_IDLE: if (fall) begin nxt = S_LOW; start = 1'b1; end
      S_LOW:
        if (s) nxt = S_HIGH;
        else if (lcnt == CNT_MAX) begin nxt = S_IDLE; sat = 1'b1; end
      S_HIGH:
        if (!s) begin nxt = S_LOW; done = 1'b1; end
        else if (hcnt == CNT_MAX) begin nxt = S_IDLE; sat = 1'b1; end
      default: nxt = S_IDLE;
    endcase
    // Disabling overrides every event; results stay untouched.
    if (!en) begin
      nxt   = S_IDLE;
      start = 1'b0;
      done  = 1'b0;
      sat   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lcnt       <= '0;
      hcnt       <= '0;
      low_len    <= '0;
      high_len   <= '0;
      meas_valid <= 1'b0;
    end else begin
      meas_valid <= done;
      if (done) begin
        low_len  <= lcnt;
        high_len <= hcnt;
      end
      unique case (st)
        S_IDLE: if (start) lcnt <= CNT_W'(1);
        S_LOW:
          if (s) hcnt <= CNT_W'(1);
          else if (lcnt != CNT_MAX) lcnt <= lcnt + 1'b1;
        S_HIGH:
          if (!s) lcnt <= CNT_W'(1);
          else if (hcnt != CNT_MAX) hcnt <= hcnt + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en    <= 1'b1;
      valid <= 1'b0;
      ovf   <= 1'b0;
      pcnt  <= 8'h00;
    end else begin
      if (wr_ctrl) en <= data_in[CTRL_EN];
      if (done) begin
        valid <= 1'b1;
        pcnt  <= pcnt + 8'd1;
      end else if (clr) begin
        valid <= 1'b0;
        pcnt  <= 8'h00;
      end
      if (sat)      ovf <= 1'b1;
      else if (clr) ovf <= 1'b0;
    end
  end

  // Byte 0 of LOW comes live (it is what the shadow captures); bytes 1..7 from the shadow.
  assign bsel = 3'(off - OFF_LOW);

  always_comb begin
    rdata = 8'h00;
    if (off == OFF_CTRL) begin
      rdata[CTRL_EN] = en;
    end else if (off == OFF_STATUS) begin
      rdata[STAT_VALID] = valid;
      rdata[STAT_OVF]   = ovf;
    end else if (off == OFF_LOW) begin
      rdata = low_len[7:0];
    end else if (off > OFF_LOW && off < OFF_PCNT) begin
      rdata = shadow[{bsel - 3'd1, 3'b000} +: 8];
    end else if (off == OFF_PCNT) begin
      rdata = pcnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= 8'h00;
      shadow   <= '0;
    end else begin
      data_out <= rdata;
      if (off == OFF_LOW) shadow <= {high_len, low_len[CNT_W-1:8]};
    end
  end

endmodule

// File: tb/tb_pwm_meter.sv
// Directed bench for pwm_meter; the filter case runs only with PWM_METER_FILTER_EN.
module tb_pwm_meter;
  import pwm_pkg::*;

  localparam logic [7:0] BASE = 8'h50;

  logic        clk = 1'b0;
  logic        res, init, we, sig_in, meas_valid;
  logic [7:0]  addr, data_in, data_out;
  logic [31:0] low_len, high_len;

  int n_cmp = 0, n_err = 0;
  int cyc = 0, pulses = 0, p_last = 0, p_prev = 0, p0;

  pwm_meter #(.CNT_W(32), .BASE(BASE)) dut (
    .clk        (clk),
    .res        (res),
    .init       (init),
    .addr       (addr),
    .data_in    (data_in),
    .we         (we),
    .data_out   (data_out),
    .sig_in     (sig_in),
    .meas_valid (meas_valid),
    .low_len    (low_len),
    .high_len   (high_len)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk)
    if (meas_valid) begin
      pulses++;
      p_prev = p_last;
      p_last = cyc;
    end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    sig_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] d;
    addr = a;
    @(posedge clk);
    #1 d = data_out;
    @(negedge clk);
    addr = 8'h00;
    chk(tag, {24'h0, d}, {24'h0, exp});
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    addr = a; data_in = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0; addr = 8'h00; data_in = 8'h00;
  endtask

  logic [7:0] exp_bytes [8];

  initial begin
    res = 1'b1; init = 1'b0; we = 1'b0; addr = 8'h00; data_in = 8'h00; sig_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_dout", {24'h0, data_out}, 32'h0);
    chk("rst_mv", {31'h0, meas_valid}, 32'h0);
    chk("rst_low", low_len, 32'h0);
    chk("rst_high", high_len, 32'h0);
    res = 1'b0;
    rd_chk("rst_ctrl", BASE, 8'h01);
    rd_chk("rst_status", BASE + 8'd1, 8'h00);

    // low 5 / high 3, four periods
    hold(1'b1, 4);
    for (int i = 0; i < 4; i++) begin
      hold(1'b0, 5);
      hold(1'b1, 3);
    end
    hold(1'b0, 4);
    chk("rep_pulses", pulses, 4);
    chk("rep_low", low_len, 5);
    chk("rep_high", high_len, 3);
    chk("rep_period", p_last - p_prev, 8);
    rd_chk("rep_pcnt", BASE + 8'd10, 8'h04);
    rd_chk("rep_status", BASE + 8'd1, 8'h01);

    // shadow coherence: capture 5/3, then a 7/4 completion
    rd_chk("shd_low0", BASE + 8'd2, 8'h05);
    hold(1'b1, 4);
    hold(1'b0, 4);
    chk("shd_live_low", low_len, 7);
    chk("shd_live_high", high_len, 4);
    rd_chk("shd_old_high", BASE + 8'd6, 8'h03);
    rd_chk("shd_new_low", BASE + 8'd2, 8'h07);
    rd_chk("shd_new_high", BASE + 8'd6, 8'h04);

    // reset in the middle of HIGH
    hold(1'b1, 3);
    chk("mid_high_state", 32'(dut.st), 32'(S_HIGH));
    res = 1'b1;
    hold(1'b1, 2);
    chk("mr_low", low_len, 0);
    chk("mr_high", high_len, 0);
    chk("mr_mv", {31'h0, meas_valid}, 0);
    chk("mr_dout", {24'h0, data_out}, 0);
    res = 1'b0;
    p0 = pulses;
    hold(1'b1, 2);
    hold(1'b0, 6);
    hold(1'b1, 2);
    chk("mr_no_early", pulses, p0);
    hold(1'b0, 4);
    chk("mr_one", pulses, p0 + 1);
    chk("mr_low2", low_len, 6);
    chk("mr_high2", high_len, 2);

    // long low 0xC345, high 0x0A
    hold(1'b1, 3);
    hold(1'b0, 32'hC345);
    hold(1'b1, 10);
    hold(1'b0, 4);
    chk("gen_low", low_len, 32'hC345);
    chk("gen_high", high_len, 32'h0A);
    exp_bytes = '{8'h45, 8'hC3, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 8; i++) rd_chk("gen_byte", BASE + 8'd2 + 8'(i), exp_bytes[i]);

    // map edges, read-only write, clear
    rd_chk("unmap_hi", BASE + 8'd11, 8'h00);
    rd_chk("unmap_lo", BASE - 8'd1, 8'h00);
    wr(BASE + 8'd1, 8'hFF);
    rd_chk("ro_status", BASE + 8'd1, 8'h01);
    wr(BASE, 8'h03);
    rd_chk("clr_status", BASE + 8'd1, 8'h00);
    rd_chk("clr_pcnt", BASE + 8'd10, 8'h00);
    rd_chk("clr_ctrl", BASE, 8'h01);

    // low counter at saturation
    p0 = pulses;
    force dut.lcnt = 32'hFFFF_FFFF;
    hold(1'b0, 3);
    release dut.lcnt;
    chk("sat_state", 32'(dut.st), 32'(S_IDLE));
    rd_chk("sat_status", BASE + 8'd1, 8'h02);
    chk("sat_low", low_len, 32'hC345);
    chk("sat_high", high_len, 32'h0A);
    chk("sat_pulses", pulses, p0);

    // disable while measuring
    hold(1'b1, 3);
    hold(1'b0, 4);
    chk("en_low", 32'(dut.st), 32'(S_LOW));
    wr(BASE, 8'h00);
    hold(1'b0, 1);
    chk("dis_idle", 32'(dut.st), 32'(S_IDLE));
    p0 = pulses;
    hold(1'b1, 3);
    hold(1'b0, 4);
    chk("dis_stay", 32'(dut.st), 32'(S_IDLE));
    chk("dis_pulses", pulses, p0);
    rd_chk("dis_ctrl", BASE, 8'h00);

    // init behaves like reset
    init = 1'b1;
    hold(1'b0, 1);
    init = 1'b0;
    rd_chk("init_ctrl", BASE, 8'h01);
    chk("init_low", low_len, 0);

`ifdef PWM_METER_FILTER_EN
    p0 = pulses;
    hold(1'b1, 4);
    hold(1'b0, 4);
    hold(1'b1, 1);
    hold(1'b0, 5);
    hold(1'b1, 3);
    chk("flt_no_pulse", pulses, p0);
    hold(1'b0, 6);
    chk("flt_one", pulses, p0 + 1);
    chk("flt_low", low_len, 10);
    chk("flt_high", high_len, 3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_meter.md
PWM_METER -- requirements
Module: pwm_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 32, counter and result width (fixed 32 in this revision).
REQ-002 SHALL have parameter BASE, default 8'h50, base of the 11-byte register window.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port res, input, 1, synchronous active-high reset.
REQ-005 SHALL have port init, input, 1, synchronous re-initialisation, same effect as res.
REQ-006 SHALL have port addr, input, 8, register byte address.
REQ-007 SHALL have port data_in, input, 8, register write data.
REQ-008 SHALL have port we, input, 1, register write strobe.
REQ-009 SHALL have port data_out, output, 8, registered read data.
REQ-010 SHALL have port sig_in, input, 1, asynchronous PWM input, low phase first.
REQ-011 SHALL have port meas_valid, output, 1, one-cycle pulse per completed period.
REQ-012 SHALL have port low_len, output, 32, last measured low-phase length in clk cycles.
REQ-013 SHALL have port high_len, output, 32, last measured high-phase length in clk cycles.

Function
REQ-014 SHALL pass sig_in through a 2-flop synchronizer; "s" is the synchronizer output.
REQ-015 SHALL implement FSM IDLE, LOW, HIGH; IDLE -> LOW on s falling edge while CTRL.en=1.
REQ-016 SHALL, in LOW, count cycles with s=0; on s=1 it SHALL go to HIGH with the high counter =1.
REQ-017 SHALL, in HIGH, count cycles with s=1; on s=0 it SHALL latch both counts into low_len/high_len, pulse meas_valid, set STATUS.valid, increment PCNT (8-bit, wraps 0xFF->0x00), go to LOW with the low counter =1.
REQ-018 SHALL saturate a counter at 0xFFFFFFFF, set STATUS.ovf (sticky), leave results unchanged and go to IDLE.
REQ-019 SHALL go to IDLE within one cycle when CTRL.en is cleared, without updating results.
REQ-020 SHALL map registers: BASE+0 CTRL (bit0 en, bit1 clear, write-1, self-clearing), BASE+1 STATUS (bit0 valid, bit1 ovf, read-only), BASE+2..5 LOW bytes LSB first, BASE+6..9 HIGH bytes LSB first, BASE+10 PCNT.
REQ-021 SHALL return read data on data_out one cycle after addr is presented, and 8'h00 for unmapped addresses.
REQ-022 SHALL capture all 8 LOW/HIGH bytes into a read shadow when addr=BASE+2 is read; BASE+3..9 SHALL read from the shadow, giving tear-free multi-byte reads.
REQ-023 SHALL clear STATUS.valid, STATUS.ovf and PCNT on a CTRL.clear write; a completion in the same cycle SHALL win for valid and PCNT.
REQ-024 SHALL let we and an FSM event in the same cycle both take effect; writes to read-only addresses SHALL be ignored.

Reset
REQ-025 SHALL, on res or init, set the FSM to IDLE, clear counters, synchronizer, shadow and registers, and drive data_out=0, meas_valid=0, low_len=0, high_len=0, with CTRL.en=1.
REQ-026 SHALL discard a partial measurement when res is asserted mid-period and SHALL resume only at the next s falling edge.

Configuration
REQ-027 SHALL, with PWM_METER_FILTER_EN defined, insert a 3-sample majority filter after the synchronizer (+1 cycle latency, pulses of 1 cycle rejected).
REQ-028 SHALL, without PWM_METER_FILTER_EN, have no filter; s is the raw synchronizer output.

Structure
REQ-029 SHALL put the register offsets, CTRL/STATUS bit positions and the FSM state enum in shared package pwm_pkg.
REQ-030 SHALL implement synchronizer plus optional filter as sub-module pwm_sync_filter.

Verification
REQ-031 SHALL cover: sig_in low 5, high 3, repeated -> low_len=5, high_len=3, meas_valid pulses every 8 cycles, PCNT increments.
REQ-032 SHALL cover: generator pattern zero=0xC345, signal=0x0A -> bytes BASE+2..9 read 45 C3 00 00 0A 00 00 00.
REQ-033 SHALL cover: sig_in held low 2^32 cycles (forced counter preload) -> STATUS=0x02, FSM IDLE, results unchanged.
REQ-034 SHALL cover: read BASE+2, then a completion, then read BASE+6 -> old HIGH value returned (shadow coherent).
REQ-035 SHALL cover: res mid-HIGH -> all outputs 0, next valid only after a full new low+high period.
REQ-036 SHALL cover: with PWM_METER_FILTER_EN, 1-cycle glitch high inside a low of 10 -> low_len=10 and no meas_valid.
